stream_arb2: RTL and testbench
==============================

// Module: stream_arb2
// PURPOSE
// - 2-requester round-robin arbiter sharing one downstream stream port via an internal MUX2 (WIDTH-bit).
// - Valid/ready on both inputs and the output; the output is registered.
// - Sits in front of any shared single-port consumer (e.g. a shared FIR/CORDIC lane) fed by two producers.
// PARAMETERS
// - WIDTH  16  data width of In0/In1/Out
// PORTS
// - Clk_CI        in   1      clock; all logic rising-edge
// - Rst_RBI       in   1      reset, synchronous, active-low
// - In0_Valid_SI  in   1      requester 0 data valid
// - In0_Data_DI   in   WIDTH  requester 0 data
// - In0_Ready_SO  out  1      requester 0 beat accepted when Valid&Ready
// - In1_Valid_SI  in   1      requester 1 data valid
// - In1_Data_DI   in   WIDTH  requester 1 data
// - In1_Ready_SO  out  1      requester 1 beat accepted when Valid&Ready
// - Out_Valid_DO  out  1      output register holds a beat
// - Out_Data_DO   out  WIDTH  output data (registered)
// - Out_Src_SO    out  1      source of beat in output register (0=In0, 1=In1)
// - Out_Ready_DI  in   1      downstream accepts when Out_Valid&Out_Ready
// - In0_Last_SI / In1_Last_SI  in 1  last beat of packet; exist only with STREAM_ARB2_PKT_LOCK_EN
// BEHAVIOUR
// - Reset (Rst_RBI=0 at edge): Out_Valid_DO=0, Out_Data_DO=0, Out_Src_SO=0, Prio=0 (In0 favoured), lock cleared.
// - Load = ~Out_Valid_DO | Out_Ready_DI; output register accepts a new beat only when Load=1.
// - Grant (combinational): only one valid -> that one; both valid -> requester Prio; none -> no grant.
// - InX_Ready_SO = Load & Grant==X; never both high; ready doesn't depend on own valid except through grant.
// - Sel to MUX2 = granted index; on accept: Out_Data_DO<=mux out, Out_Src_SO<=Sel, Out_Valid_DO<=1.
// - Load=1 with no grant: Out_Valid_DO<=0 (a drained beat is not replaced).
// - Out_Valid_DO=1 & Out_Ready_DI=0: Out_Data_DO/Out_Src_SO held stable; both readies 0.
// - Latency 1 cycle input accept -> Out_Valid_DO; throughput 1 beat/cycle (simultaneous drain+load allowed).
// - Prio update: after an accepted beat from X, Prio<=~X; no accept -> Prio unchanged.
// - Fairness: with both valid continuously and Out_Ready_DI=1, grants strictly alternate 0,1,0,1...
// - A requester dropping valid without a handshake is not an error; grant re-evaluated each cycle.
// - Reset mid-operation: beat in output register discarded; no partial state survives.
// CONFIGURATION
// - STREAM_ARB2_PKT_LOCK_EN defined: adds InX_Last_SI; FSM IDLE/LOCK0/LOCK1.
//   - IDLE: grant as above; accept from X with Last=0 -> LOCKX; Last=1 -> stay IDLE.
//   - LOCKX: grant forced to X even if X not valid (other side stalls); accept with Last=1 -> IDLE.
//   - Prio updates only on Last beats; reset -> IDLE.
// - Undefined: no Last ports, no FSM; arbitration per beat as above.
// TESTING
// - Reset: Rst_RBI=0 2 cycles, all valids 1 -> Out_Valid_DO=0, readies 0 during reset, Out_Data_DO=0.
// - Single requester: In1 valid, data 0x0001..0x0004, Out_Ready=1 -> Out_Data 1..4, Src=1, 1-cycle lag.
// - Contention: both valid continuously, In0=0xA000+n, In1=0xB000+n -> out A000,B000,A001,B001...
// - Backpressure: Out_Ready=0 for 5 cycles with out beat 0xA000 -> data/Src held, readies 0, no loss.
// - Drain w/o refill: one beat then valids 0 with Out_Ready=1 -> Out_Valid_DO falls next cycle.
// - PKT_LOCK_EN: In0 3-beat packet, In1 valid throughout -> 3 In0 beats contiguous, then In1.

Source files
------------

// File: rtl/stream_arb2.sv
// Two-requester round-robin stream arbiter with a registered output stage.
// Define STREAM_ARB2_PKT_LOCK_EN to hold the grant until a packet's Last beat.
module stream_arb2 #(
  parameter int WIDTH = 16
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             In0_Valid_SI,
  input  logic [WIDTH-1:0] In0_Data_DI,
`ifdef STREAM_ARB2_PKT_LOCK_EN
  input  logic             In0_Last_SI,
`endif
  output logic             In0_Ready_SO,
  input  logic             In1_Valid_SI,
  input  logic [WIDTH-1:0] In1_Data_DI,
`ifdef STREAM_ARB2_PKT_LOCK_EN
  input  logic             In1_Last_SI,
`endif
  output logic             In1_Ready_SO,
  output logic             Out_Valid_DO,
  output logic [WIDTH-1:0] Out_Data_DO,
  output logic             Out_Src_SO,
  input  logic             Out_Ready_DI
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             prio_q, prio_d;

  logic             in_valid [2];
  logic [WIDTH-1:0] in_data [2];
  logic             load;
  logic             grant_vld;
  logic             grant_sel;
  logic             accept;
  logic             accept_last;
  logic [WIDTH-1:0] mux_data;

  assign in_valid[0] = In0_Valid_SI;
  assign in_valid[1] = In1_Valid_SI;
  assign in_data[0]  = In0_Data_DI;
  assign in_data[1]  = In1_Data_DI;

  assign load     = ~out_valid_q | Out_Ready_DI;
  assign mux_data = in_data[grant_sel];

  // Readies are masked during reset so no producer sees a false handshake.
  assign In0_Ready_SO = Rst_RBI & load & grant_vld & (grant_sel == 1'b0);
  assign In1_Ready_SO = Rst_RBI & load & grant_vld & (grant_sel == 1'b1);
  assign accept       = Rst_RBI & load & grant_vld & in_valid[grant_sel];

`ifdef STREAM_ARB2_PKT_LOCK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;
  logic        in_last [2];

  assign in_last[0]  = In0_Last_SI;
  assign in_last[1]  = In1_Last_SI;
  assign accept_last = in_last[grant_sel];

  // While locked the owner keeps the grant even without valid; the other side stalls.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case (state_q)
      LOCK0: begin
        grant_vld = 1'b1;
        grant_sel = 1'b0;
      end
      LOCK1: begin
        grant_vld = 1'b1;
        grant_sel = 1'b1;
      end
      default: begin
        if (in_valid[0] && in_valid[1]) begin
          grant_vld = 1'b1;
          grant_sel = prio_q;
        end else if (in_valid[0] || in_valid[1]) begin
          grant_vld = 1'b1;
          grant_sel = in_valid[1];
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (accept_last) begin
        state_d = IDLE;
      end else begin
        state_d = grant_sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign accept_last = 1'b1;

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (in_valid[0] && in_valid[1]) begin
      grant_vld = 1'b1;
      grant_sel = prio_q;
    end else if (in_valid[0] || in_valid[1]) begin
      grant_vld = 1'b1;
      grant_sel = in_valid[1];
    end
  end
`endif

  // Priority moves away from the winner only when its beat (or packet) completes.
  always_comb begin
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept && accept_last) begin
      prio_d = ~grant_sel;
    end
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = mux_data;
        out_src_d  = grant_sel;
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      prio_q      <= prio_d;
    end
  end

  assign Out_Valid_DO = out_valid_q;
  assign Out_Data_DO  = out_data_q;
  assign Out_Src_SO   = out_src_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: directed scenarios plus a randomized run
// against a queue-based reference model (also covers STREAM_ARB2_PKT_LOCK_EN).
module tb_stream_arb2;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             v0, v1, r0, r1, ov, os, ordy;
  logic [WIDTH-1:0] d0, d1, od;
`ifdef STREAM_ARB2_PKT_LOCK_EN
  logic             l0, l1;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_arb2 #(.WIDTH(WIDTH)) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .In0_Valid_SI (v0),
    .In0_Data_DI  (d0),
`ifdef STREAM_ARB2_PKT_LOCK_EN
    .In0_Last_SI  (l0),
`endif
    .In0_Ready_SO (r0),
    .In1_Valid_SI (v1),
    .In1_Data_DI  (d1),
`ifdef STREAM_ARB2_PKT_LOCK_EN
    .In1_Last_SI  (l1),
`endif
    .In1_Ready_SO (r1),
    .Out_Valid_DO (ov),
    .Out_Data_DO  (od),
    .Out_Src_SO   (os),
    .Out_Ready_DI (ordy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ordy = 1'b1;
`ifdef STREAM_ARB2_PKT_LOCK_EN
    l0 = 1'b1; l1 = 1'b1;
`endif
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 16'h1234; d1 = 16'h5678; ordy = 1'b1;
`ifdef STREAM_ARB2_PKT_LOCK_EN
    l0 = 1'b0; l1 = 1'b0;
`endif
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (r0 !== 1'b0 || r1 !== 1'b0) begin
        n_err++; $display("FAIL reset_ready: got r0=%b r1=%b, want 0 0", r0, r1);
      end
      tick();
      n_cmp++;
      if (ov !== 1'b0 || od !== 16'h0 || os !== 1'b0) begin
        n_err++; $display("FAIL reset_out: got v=%b d=%h s=%b, want 0 0000 0", ov, od, os);
      end
    end
    $display("reset: checked outputs over 2 reset cycles");
    v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    v1 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      d1 = WIDTH'(n);
      #1;
      n_cmp++;
      if (r1 !== 1'b1 || r0 !== 1'b0) begin
        n_err++; $display("FAIL single_ready: beat %0d got r0=%b r1=%b, want 0 1", n, r0, r1);
      end
      tick();
      n_cmp++;
      if (ov !== 1'b1 || od !== WIDTH'(n) || os !== 1'b1) begin
        n_err++; $display("FAIL single_out: got v=%b d=%h s=%b, want 1 %h 1", ov, od, os, WIDTH'(n));
      end
      $display("single: beat %0d out=%h src=%b", n, od, os);
    end
    v1 = 1'b0;
    tick();
    n_cmp++;
    if (ov !== 1'b0) begin
      n_err++; $display("FAIL drain: got out_valid=%b, want 0", ov);
    end
    $display("drain: out_valid=%b after valids dropped", ov);
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    logic [WIDTH-1:0] exp_d;
    do_reset();
    v0 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d0 = 16'hA000 + WIDTH'(n0);
      d1 = 16'hB000 + WIDTH'(n1);
      #1;
      n_cmp++;
      if (r0 !== ((k % 2) == 0) || r1 !== ((k % 2) == 1)) begin
        n_err++; $display("FAIL contend_grant: cycle %0d got r0=%b r1=%b, want src %0d", k, r0, r1, k % 2);
      end
      if (r0 === 1'b1) n0++;
      if (r1 === 1'b1) n1++;
      tick();
      exp_d = ((k % 2) == 0) ? 16'hA000 + WIDTH'(k / 2) : 16'hB000 + WIDTH'(k / 2);
      n_cmp++;
      if (ov !== 1'b1 || od !== exp_d || os !== 1'((k % 2) == 1)) begin
        n_err++; $display("FAIL contend_out: cycle %0d got %h src %b, want %h src %0d", k, od, os, exp_d, k % 2);
      end
      $display("contention: cycle %0d out=%h src=%b", k, od, os);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    v0 = 1'b1; v1 = 1'b1; d0 = 16'hA000; d1 = 16'hB000; ordy = 1'b1;
    tick();
    ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (r0 !== 1'b0 || r1 !== 1'b0 || ov !== 1'b1 || od !== 16'hA000 || os !== 1'b0) begin
        n_err++; $display("FAIL bp_hold: cycle %0d got r=%b%b v=%b d=%h s=%b, want r=00 v=1 d=a000 s=0",
                          c, r0, r1, ov, od, os);
      end
      tick();
    end
    ordy = 1'b1; v0 = 1'b0;
    #1;
    n_cmp++;
    if (r1 !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got r1=%b, want 1", r1);
    end
    tick();
    v1 = 1'b0;
    n_cmp++;
    if (ov !== 1'b1 || od !== 16'hB000 || os !== 1'b1) begin
      n_err++; $display("FAIL bp_next: got v=%b d=%h s=%b, want 1 b000 1", ov, od, os);
    end
    $display("backpressure: held a000 5 cycles, then out=%h src=%b", od, os);
    ordy = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (ov !== 1'b0 || od !== 16'h0) begin
      n_err++; $display("FAIL midreset: got v=%b d=%h, want 0 0000", ov, od);
    end
    $display("midreset: out_valid=%b", ov);
    ordy = 1'b1;
  endtask

`ifdef STREAM_ARB2_PKT_LOCK_EN
  task automatic test_pkt_lock();
    logic [4:0]       tv0;
    logic [4:0]       tl0;
    logic [4:0]       er0;
    logic [4:0]       eov;
    logic [4:0]       esrc;
    logic [WIDTH-1:0] edat [5];
    int               b = 0;
    tv0 = 5'b01011; tl0 = 5'b01000; er0 = 5'b01111; eov = 5'b11011; esrc = 5'b10000;
    edat[0] = 16'hC000; edat[1] = 16'hC001; edat[2] = 16'h0000; edat[3] = 16'hC002; edat[4] = 16'hB000;
    do_reset();
    v1 = 1'b1; l1 = 1'b1; d1 = 16'hB000;
    for (int c = 0; c < 5; c++) begin
      v0 = tv0[c]; l0 = tl0[c]; d0 = 16'hC000 + WIDTH'(b);
      #1;
      n_cmp++;
      if (r0 !== er0[c] || r1 !== !er0[c]) begin
        n_err++; $display("FAIL lock_grant: cycle %0d got r0=%b r1=%b, want %b %b", c, r0, r1, er0[c], !er0[c]);
      end
      if (r0 === 1'b1 && v0 === 1'b1) b++;
      tick();
      n_cmp++;
      if (ov !== eov[c] || (eov[c] && (od !== edat[c] || os !== esrc[c]))) begin
        n_err++; $display("FAIL lock_out: cycle %0d got v=%b d=%h s=%b, want v=%b d=%h s=%b",
                          c, ov, od, os, eov[c], edat[c], esrc[c]);
      end
      $display("pkt_lock: cycle %0d out_valid=%b out=%h src=%b", c, ov, od, os);
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [WIDTH:0] exp_q [$];
    logic [WIDTH:0] front;
    bit  m_ov = 0;
    bit  m_prio = 0;
    int  lock_owner = -1;
    bit  load, gv, gs, acc, last;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      d0 = WIDTH'($urandom);
      d1 = WIDTH'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
`ifdef STREAM_ARB2_PKT_LOCK_EN
      l0 = $urandom_range(0, 1) == 1;
      l1 = $urandom_range(0, 1) == 1;
`endif
      #1;
      load = !m_ov || ordy;
      gv = 1'b0; gs = 1'b0;
      if (lock_owner >= 0) begin gv = 1'b1; gs = (lock_owner == 1); end
      else if (v0 && v1) begin gv = 1'b1; gs = m_prio; end
      else if (v0 || v1) begin gv = 1'b1; gs = v1; end
      acc = load && gv && (gs ? v1 : v0);
`ifdef STREAM_ARB2_PKT_LOCK_EN
      last = gs ? l1 : l0;
`else
      last = 1'b1;
`endif
      n_cmp++;
      if (ov !== m_ov || r0 !== (load && gv && !gs) || r1 !== (load && gv && gs)) begin
        n_err++; $display("FAIL rand_ctl: cycle %0d got v=%b r=%b%b, want v=%b r=%b%b",
                          c, ov, r0, r1, m_ov, load && gv && !gs, load && gv && gs);
      end
      if (m_ov && ordy) begin
        front = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_cmp++;
        if ({os, od} !== front) begin
          n_err++; $display("FAIL rand_data: cycle %0d got src %b data %h, want src %b data %h",
                            c, os, od, front[WIDTH], front[WIDTH-1:0]);
        end
        $display("random: cycle %0d drained src=%b data=%h", c, os, od);
      end
      if (acc) begin
        exp_q.push_back({gs, gs ? d1 : d0});
        if (last) m_prio = !gs;
`ifdef STREAM_ARB2_PKT_LOCK_EN
        lock_owner = last ? -1 : int'(gs);
`endif
      end
      if (load) m_ov = acc;
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
`ifdef STREAM_ARB2_PKT_LOCK_EN
    test_pkt_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
